data_mem_ctrl: RTL and testbench

- Data-memory slave on the core's load-store port: the stage directly downstream of the core's LoadStore pipe stage, which issues its requests.
- Single-port word-organised SRAM model with byte/half/word access, programmable wait states, and address-error detection.
- Returns loads right-justified and sign- or zero-extended.
- Handshaked request/acknowledge, so a later stall-capable pipeline can use it unchanged.

---
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load-store port bundle between the core's LoadStore stage (master) and data memory (slave).
// Latency: n/a (wiring only). Backpressure: slave drops ready while inserting wait states.
// Signals: req/write/l_unsigned/n_bytes/addr/wr_data (request), ready/ack/rd_data/addr_err (response), cnt_* (statistics).
interface data_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            write;
  logic            l_unsigned;
  logic [1:0]      n_bytes;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wr_data;
  logic            ready;
  logic            ack;
  logic [XLEN-1:0] rd_data;
  logic            addr_err;
  logic [31:0]     cnt_loads;
  logic [31:0]     cnt_stores;
  logic [31:0]     cnt_errors;

  modport master (
    output req, write, l_unsigned, n_bytes, addr, wr_data,
    input  ready, ack, rd_data, addr_err, cnt_loads, cnt_stores, cnt_errors
  );

  modport slave (
    input  req, write, l_unsigned, n_bytes, addr, wr_data,
    output ready, ack, rd_data, addr_err, cnt_loads, cnt_stores, cnt_errors
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: word SRAM model with byte/half/word access, sign/zero-extended loads, address-error detection.
// Latency: ack exactly 1+WAIT_STATES cycles after the accepting edge; one access per cycle when WAIT_STATES=0.
// Backpressure: ready low only while counting wait states; ack is a single-cycle pulse (no response stall).
// Ports: clk, rstn (async active-low), bus (data_mem_ctrl_if.slave).
// Optional: define DMEM_ACCESS_COUNTERS_EN to enable the load/store/error counters (otherwise tied to 0).
// The array is organised as 32-bit words with four byte lanes, so XLEN is expected to be 32.
module data_mem_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_2000,
  parameter int              WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rstn,
  data_mem_ctrl_if.slave bus
);

  localparam int        IDXW    = $clog2(DEPTH_WORDS);
  localparam bit        NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [3:0]      wcnt;
  logic            c_write, c_uns;
  logic [1:0]      c_nb;
  logic [XLEN-1:0] c_addr, c_wdata;
  logic [XLEN-1:0] rd_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic accept, commit, in_wait;
  assign in_wait = (state == S_WAIT);
  assign accept  = bus.req & ~in_wait;
  // The array is touched on the edge that enters RESP: the accept edge itself
  // when there are no wait states, otherwise the edge leaving WAIT.
  assign commit  = (accept && NO_WAIT) || (in_wait && wcnt == 4'd0);

  // Request actually being committed: live inputs, or the captured copy after waiting.
  logic            s_write, s_uns;
  logic [1:0]      s_nb;
  logic [XLEN-1:0] s_addr, s_wdata;
  assign s_write = in_wait ? c_write : bus.write;
  assign s_uns   = in_wait ? c_uns   : bus.l_unsigned;
  assign s_nb    = in_wait ? c_nb    : bus.n_bytes;
  assign s_addr  = in_wait ? c_addr  : bus.addr;
  assign s_wdata = in_wait ? c_wdata : bus.wr_data;

  // Range limits are compared one bit wider so BASE_ADDR+size cannot overflow.
  logic [XLEN:0] lim;
  assign lim = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);

  logic err;
  always_comb begin
    err = 1'b0;
    case (s_nb)
      2'd1:    if (s_addr[0]) err = 1'b1;
      2'd2:    if (s_addr[1:0] != 2'd0) err = 1'b1;
      2'd3:    err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({1'b0, s_addr} < {1'b0, BASE_ADDR} || {1'b0, s_addr} >= lim) err = 1'b1;
  end

  // BASE_ADDR is word aligned, so subtracting the word-index slices is exact.
  logic [IDXW-1:0] idx;
  assign idx = s_addr[IDXW+1:2] - BASE_ADDR[IDXW+1:2];

  logic [3:0]      be;
  logic [XLEN-1:0] wsh, lane, ld;
  always_comb begin
    case (s_nb)
      2'd0:    be = 4'b0001 << s_addr[1:0];
      2'd1:    be = 4'b0011 << s_addr[1:0];
      default: be = 4'b1111;
    endcase
    wsh  = s_wdata << {s_addr[1:0], 3'b000};
    lane = mem[idx] >> {s_addr[1:0], 3'b000};
    case (s_nb)
      2'd0:    ld = s_uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    ld = s_uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld = lane;
    endcase
  end

  // Array is not reset; rstn gating keeps a request seen during reset from writing.
  always_ff @(posedge clk) begin
    if (rstn && commit && s_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      c_write <= 1'b0;
      c_uns   <= 1'b0;
      c_nb    <= 2'd0;
      c_addr  <= '0;
      c_wdata <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        c_write <= bus.write;
        c_uns   <= bus.l_unsigned;
        c_nb    <= bus.n_bytes;
        c_addr  <= bus.addr;
        c_wdata <= bus.wr_data;
      end
      if (commit) begin
        err_q <= err;
        if (err)           rd_q <= '0;
        else if (!s_write) rd_q <= ld;
      end
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              wcnt  <= WS_INIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready    = ~in_wait;
  assign bus.ack      = (state == S_RESP);
  assign bus.rd_data  = rd_q;
  assign bus.addr_err = (state == S_RESP) & err_q;

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic        resp_write;
  logic [31:0] cnt_l, cnt_s, cnt_e;
  // Counters step on the edge that closes the ack cycle; errors count only as errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_write <= 1'b0;
      cnt_l      <= 32'd0;
      cnt_s      <= 32'd0;
      cnt_e      <= 32'd0;
    end else begin
      if (commit) resp_write <= s_write;
      if (state == S_RESP) begin
        if (err_q)           cnt_e <= cnt_e + 32'd1;
        else if (resp_write) cnt_s <= cnt_s + 32'd1;
        else                 cnt_l <= cnt_l + 32'd1;
      end
    end
  end
  assign bus.cnt_loads  = cnt_l;
  assign bus.cnt_stores = cnt_s;
  assign bus.cnt_errors = cnt_e;
`else
  assign bus.cnt_loads  = 32'd0;
  assign bus.cnt_stores = 32'd0;
  assign bus.cnt_errors = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with no wait states, one with three.
// Latency: checks ack timing per instance. Backpressure: checks ready during wait states.
// Outputs are sampled 1 time unit after the rising edge.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rstn0 = 1'b0;
  logic rstn3 = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.XLEN(32)) b0 ();
  data_mem_ctrl_if #(.XLEN(32)) b3 ();

  data_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(0))
    u0 (.clk(clk), .rstn(rstn0), .bus(b0));
  data_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3))
    u3 (.clk(clk), .rstn(rstn3), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request to the zero-wait instance; returns #1 after the accept edge.
  task automatic acc0(input logic w, input logic u, input logic [1:0] nb,
                      input logic [31:0] a, input logic [31:0] wd);
    b0.req = 1'b1; b0.write = w; b0.l_unsigned = u; b0.n_bytes = nb;
    b0.addr = a; b0.wr_data = wd;
    @(posedge clk); #1;
    b0.req = 1'b0;
  endtask

  task automatic set3(input logic w, input logic [1:0] nb, input logic [31:0] a, input logic [31:0] wd);
    b3.write = w; b3.l_unsigned = 1'b0; b3.n_bytes = nb; b3.addr = a; b3.wr_data = wd;
  endtask

  `ifdef DMEM_ACCESS_COUNTERS_EN
  localparam logic [31:0] EXP_L = 32'd3, EXP_S = 32'd2, EXP_E = 32'd1;
  `else
  localparam logic [31:0] EXP_L = 32'd0, EXP_S = 32'd0, EXP_E = 32'd0;
  `endif

  initial begin
    int cyc;
    int nack;
    b0.req = 1'b0; b0.write = 1'b0; b0.l_unsigned = 1'b0; b0.n_bytes = 2'd0; b0.addr = '0; b0.wr_data = '0;
    b3.req = 1'b0; b3.write = 1'b0; b3.l_unsigned = 1'b0; b3.n_bytes = 2'd0; b3.addr = '0; b3.wr_data = '0;
    #22; rstn0 = 1'b1; rstn3 = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ready", 32'(b0.ready), 32'd1);
    chk("rst_ack", 32'(b0.ack), 32'd0);
    chk("rst_rd", b0.rd_data, 32'd0);
    chk("rst_err", 32'(b0.addr_err), 32'd0);
    chk("rst_cnt_l", b0.cnt_loads, 32'd0);
    chk("rst_cnt_s", b0.cnt_stores, 32'd0);
    chk("rst_cnt_e", b0.cnt_errors, 32'd0);

    // Back-to-back store/load word with no wait states
    acc0(1'b1, 1'b0, 2'd2, 32'h2000, 32'hDEADBEEF);
    chk("st_w_ack", 32'(b0.ack), 32'd1);
    chk("st_w_err", 32'(b0.addr_err), 32'd0);
    acc0(1'b0, 1'b0, 2'd2, 32'h2000, 32'h0);
    chk("ld_w_ack", 32'(b0.ack), 32'd1);
    chk("ld_w_rd", b0.rd_data, 32'hDEADBEEF);
    chk("ld_w_err", 32'(b0.addr_err), 32'd0);
    @(posedge clk); #1;
    chk("idle_ack", 32'(b0.ack), 32'd0);
    chk("idle_rd_hold", b0.rd_data, 32'hDEADBEEF);

    // Byte lanes and extension
    acc0(1'b1, 1'b0, 2'd2, 32'h2004, 32'h11223344);
    acc0(1'b1, 1'b0, 2'd0, 32'h2005, 32'h00000080);
    acc0(1'b0, 1'b0, 2'd0, 32'h2005, 32'h0);
    chk("ld_b_s", b0.rd_data, 32'hFFFFFF80);
    acc0(1'b0, 1'b1, 2'd0, 32'h2005, 32'h0);
    chk("ld_b_u", b0.rd_data, 32'h00000080);
    acc0(1'b0, 1'b0, 2'd2, 32'h2004, 32'h0);
    chk("ld_w_lanes", b0.rd_data, 32'h11228044);
    acc0(1'b1, 1'b0, 2'd2, 32'h2010, 32'h55555555);
    chk("st_rd_hold", b0.rd_data, 32'h11228044);
    acc0(1'b0, 1'b0, 2'd1, 32'h2004, 32'h0);
    chk("ld_h_s", b0.rd_data, 32'hFFFF8044);
    acc0(1'b0, 1'b1, 2'd1, 32'h2006, 32'h0);
    chk("ld_h_u_hi", b0.rd_data, 32'h00001122);

    // Error cases
    acc0(1'b0, 1'b0, 2'd1, 32'h2003, 32'h0);
    chk("e_half_err", 32'(b0.addr_err), 32'd1);
    chk("e_half_rd", b0.rd_data, 32'd0);
    acc0(1'b0, 1'b0, 2'd2, 32'h2000, 32'h0);
    chk("reload_w", b0.rd_data, 32'hDEADBEEF);
    acc0(1'b0, 1'b0, 2'd2, 32'h2002, 32'h0);
    chk("e_word_err", 32'(b0.addr_err), 32'd1);
    chk("e_word_rd", b0.rd_data, 32'd0);
    acc0(1'b0, 1'b0, 2'd2, 32'h1FFC, 32'h0);
    chk("e_low_err", 32'(b0.addr_err), 32'd1);
    acc0(1'b0, 1'b0, 2'd3, 32'h2004, 32'h0);
    chk("e_nb3_err", 32'(b0.addr_err), 32'd1);
    chk("e_nb3_ack", 32'(b0.ack), 32'd1);
    acc0(1'b0, 1'b0, 2'd2, 32'h6000, 32'h0);
    chk("e_high_err", 32'(b0.addr_err), 32'd1);
    acc0(1'b1, 1'b0, 2'd2, 32'h5FFC, 32'h0BADF00D);
    chk("top_word_ok", 32'(b0.addr_err), 32'd0);
    acc0(1'b1, 1'b0, 2'd2, 32'h2006, 32'hFFFFFFFF);
    chk("e_st_err", 32'(b0.addr_err), 32'd1);
    acc0(1'b1, 1'b0, 2'd3, 32'h2004, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("err_idle_ack", 32'(b0.ack), 32'd0);
    chk("err_idle_flag", 32'(b0.addr_err), 32'd0);
    acc0(1'b0, 1'b0, 2'd2, 32'h2004, 32'h0);
    chk("mem_unchanged", b0.rd_data, 32'h11228044);
    acc0(1'b0, 1'b0, 2'd2, 32'h5FFC, 32'h0);
    chk("top_word_rd", b0.rd_data, 32'h0BADF00D);

    // Three wait states, request held high
    chk("ws3_ready0", 32'(b3.ready), 32'd1);
    b3.req = 1'b1; set3(1'b1, 2'd2, 32'h2000, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("ws3_c1_ready", 32'(b3.ready), 32'd0);
    chk("ws3_c1_ack", 32'(b3.ack), 32'd0);
    set3(1'b0, 2'd2, 32'h2000, 32'h0);
    @(posedge clk); #1;
    chk("ws3_c2_ready", 32'(b3.ready), 32'd0);
    @(posedge clk); #1;
    chk("ws3_c3_ready", 32'(b3.ready), 32'd0);
    chk("ws3_c3_ack", 32'(b3.ack), 32'd0);
    @(posedge clk); #1;
    chk("ws3_c4_ack", 32'(b3.ack), 32'd1);
    chk("ws3_c4_ready", 32'(b3.ready), 32'd1);
    @(posedge clk); #1;  // load accepted on the ack cycle's closing edge
    b3.req = 1'b0;
    chk("ws3_next_ready", 32'(b3.ready), 32'd0);
    cyc = 1;
    while (cyc <= 10 && b3.ack !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ws3_latency", 32'(cyc), 32'd4);
    chk("ws3_ld_rd", b3.rd_data, 32'hCAFEF00D);

    // Reset while a store is waiting
    b3.req = 1'b1; set3(1'b1, 2'd2, 32'h2000, 32'h12345678);
    @(posedge clk); #1;
    b3.req = 1'b0;
    rstn3 = 1'b0; #2;
    chk("rst3_ready", 32'(b3.ready), 32'd1);
    chk("rst3_ack", 32'(b3.ack), 32'd0);
    rstn3 = 1'b1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b3.ack === 1'b1) nack++;
    end
    chk("rst3_no_ack", 32'(nack), 32'd0);
    b3.req = 1'b1; set3(1'b0, 2'd2, 32'h2000, 32'h0);
    @(posedge clk); #1;
    b3.req = 1'b0;
    cyc = 1;
    while (cyc <= 10 && b3.ack !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst3_ld_lat", 32'(cyc), 32'd4);
    chk("rst3_old_data", b3.rd_data, 32'hCAFEF00D);

    // Counters: fresh reset, then 3 loads, 2 stores, 1 misaligned
    rstn0 = 1'b0; #2; rstn0 = 1'b1;
    @(posedge clk); #1;
    acc0(1'b0, 1'b0, 2'd2, 32'h2000, 32'h0);
    acc0(1'b1, 1'b0, 2'd2, 32'h2010, 32'h01020304);
    acc0(1'b0, 1'b0, 2'd2, 32'h2004, 32'h0);
    acc0(1'b1, 1'b0, 2'd0, 32'h2011, 32'h000000AA);
    acc0(1'b0, 1'b1, 2'd1, 32'h2003, 32'h0);
    acc0(1'b0, 1'b1, 2'd0, 32'h2011, 32'h0);
    chk("cnt_ld_rd", b0.rd_data, 32'h000000AA);
    @(posedge clk); #1;
    chk("cnt_loads", b0.cnt_loads, EXP_L);
    chk("cnt_stores", b0.cnt_stores, EXP_S);
    chk("cnt_errors", b0.cnt_errors, EXP_E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
